// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronizes start/clear buttons and runs an IDLE/RUN/PAUSE/OVF FSM over a BCD hundredths counter.
// A button edge acts 3 edges after it is first sampled; all outputs are registered and the block never stalls.

module stopwatch_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk100MHz,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    output logic [15:0] bcd,
    output logic        running,
    output logic        overflow
);

    localparam int LOOP = CLK_HZ / TICK_HZ;
    localparam int PW   = $clog2(LOOP);
    localparam logic [PW-1:0] PS_LAST = PW'(LOOP - 1);
    localparam logic [PW-1:0] PS_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVF   = 2'd3
    } state_t;

    logic          r_ss_meta;
    logic          r_ss_sync;
    logic          r_ss_hist;
    logic          r_ss_pls;
    logic          r_cl_meta;
    logic          r_cl_sync;
    logic          r_cl_hist;
    logic          r_cl_pls;

    state_t        r_state;
    logic [15:0]   r_bcd;
    logic [PW-1:0] r_ps;
    logic          r_running;
    logic          r_overflow;

    logic          w_tick;
    logic          w_bcd_max;
    logic [15:0]   w_bcd_next;

    function automatic logic [15:0] bcd_incr(input logic [15:0] v);
        logic [15:0] res;
        logic        cy;
        res = v;
        cy  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cy) begin
                if (v[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    cy            = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Sync stages reset high so a button held through reset must be released before it can fire.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            r_ss_meta <= 1'b1;
            r_ss_sync <= 1'b1;
            r_ss_hist <= 1'b1;
            r_ss_pls  <= 1'b0;
            r_cl_meta <= 1'b1;
            r_cl_sync <= 1'b1;
            r_cl_hist <= 1'b1;
            r_cl_pls  <= 1'b0;
        end else begin
            r_ss_meta <= start_stop;
            r_ss_sync <= r_ss_meta;
            r_ss_hist <= r_ss_sync;
            r_ss_pls  <= r_ss_sync & ~r_ss_hist;
            r_cl_meta <= clear;
            r_cl_sync <= r_cl_meta;
            r_cl_hist <= r_cl_sync;
            r_cl_pls  <= r_cl_sync & ~r_cl_hist;
        end
    end

    assign w_tick     = (r_state == ST_RUN) && (r_ps == PS_LAST);
    assign w_bcd_max  = (r_bcd == 16'h9999);
    assign w_bcd_next = bcd_incr(r_bcd);

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bcd      <= 16'h0000;
            r_ps       <= '0;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bcd <= 16'h0000;
                    r_ps  <= '0;
                    if (r_ss_pls && !r_cl_pls) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_cl_pls) begin
                        r_state    <= ST_IDLE;
                        r_bcd      <= 16'h0000;
                        r_ps       <= '0;
                        r_running  <= 1'b0;
                        r_overflow <= 1'b0;
                    end else begin
                        r_ps <= w_tick ? '0 : r_ps + PS_ONE;
                        // Saturate at 99.99: the last tick only flags overflow.
                        if (w_tick && w_bcd_max) begin
                            r_state    <= ST_OVF;
                            r_running  <= 1'b0;
                            r_overflow <= 1'b1;
                        end else begin
                            if (w_tick) begin
                                r_bcd <= w_bcd_next;
                            end
                            if (r_ss_pls) begin
                                r_state   <= ST_PAUSE;
                                r_running <= 1'b0;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (r_cl_pls) begin
                        r_state    <= ST_IDLE;
                        r_bcd      <= 16'h0000;
                        r_ps       <= '0;
                        r_running  <= 1'b0;
                        r_overflow <= 1'b0;
                    end else if (r_ss_pls) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_OVF: begin
                    r_bcd <= 16'h9999;
                    if (r_cl_pls) begin
                        r_state    <= ST_IDLE;
                        r_bcd      <= 16'h0000;
                        r_ps       <= '0;
                        r_running  <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bcd      = r_bcd;
    assign running  = r_running;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (LOOP=10 and LOOP=2) share inputs and are checked every cycle
// against a model that counts elapsed RUN cycles; directed sequences pin down latencies and corner cases.

module tb_stopwatch_ctrl;

    localparam int LOOP_A = 10;
    localparam int LOOP_B = 2;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear      = 1'b0;
    logic [15:0] bcd_a;
    logic [15:0] bcd_b;
    logic        running_a;
    logic        running_b;
    logic        overflow_a;
    logic        overflow_b;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) u_dut_a (
        .clk100MHz  (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .bcd        (bcd_a),
        .running    (running_a),
        .overflow   (overflow_a)
    );

    stopwatch_ctrl #(.CLK_HZ(200), .TICK_HZ(100)) u_dut_b (
        .clk100MHz  (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .bcd        (bcd_b),
        .running    (running_b),
        .overflow   (overflow_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_OVF} mode_t;

    mode_t      m_mode [2];
    int         m_n    [2];
    logic [3:0] m_shist;
    logic [3:0] m_chist;
    bit         m_live = 1'b0;

    function automatic logic [15:0] to_bcd(input int t);
        return {4'(t / 1000 % 10), 4'(t / 100 % 10), 4'(t / 10 % 10), 4'(t % 10)};
    endfunction

    function automatic int loop_of(input int i);
        return (i == 0) ? LOOP_A : LOOP_B;
    endfunction

    // Reference: bcd is simply (RUN cycles since last clear) / LOOP, saturating into OVF at 10000 ticks.
    initial begin
        logic        s_in, c_in, r_in, sp, cp;
        int          nn, lp;
        logic [15:0] e_bcd;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE;
            m_n[i]    = 0;
        end
        m_shist = 4'hF;
        m_chist = 4'hF;
        forever begin
            @(posedge clk);
            s_in = start_stop;
            c_in = clear;
            r_in = rst;
            #1;
            if (r_in) begin
                for (int i = 0; i < 2; i++) begin
                    m_mode[i] = M_IDLE;
                    m_n[i]    = 0;
                end
                m_shist = 4'hF;
                m_chist = 4'hF;
                m_live  = 1'b1;
            end else begin
                sp = m_shist[2] & ~m_shist[3];
                cp = m_chist[2] & ~m_chist[3];
                for (int i = 0; i < 2; i++) begin
                    lp = loop_of(i);
                    case (m_mode[i])
                        M_IDLE: begin
                            m_n[i] = 0;
                            if (sp && !cp) m_mode[i] = M_RUN;
                        end
                        M_RUN: begin
                            if (cp) begin
                                m_mode[i] = M_IDLE;
                                m_n[i]    = 0;
                            end else begin
                                nn = m_n[i] + 1;
                                if ((nn % lp == 0) && (nn / lp == 10000)) begin
                                    m_mode[i] = M_OVF;
                                end else begin
                                    m_n[i] = nn;
                                    if (sp) m_mode[i] = M_PAUSE;
                                end
                            end
                        end
                        M_PAUSE: begin
                            if (cp) begin
                                m_mode[i] = M_IDLE;
                                m_n[i]    = 0;
                            end else if (sp) begin
                                m_mode[i] = M_RUN;
                            end
                        end
                        M_OVF: begin
                            if (cp) begin
                                m_mode[i] = M_IDLE;
                                m_n[i]    = 0;
                            end
                        end
                    endcase
                end
                m_shist = {m_shist[2:0], s_in};
                m_chist = {m_chist[2:0], c_in};
            end
            if (m_live) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_mode[i] == M_IDLE)     e_bcd = 16'h0000;
                    else if (m_mode[i] == M_OVF) e_bcd = 16'h9999;
                    else                         e_bcd = to_bcd(m_n[i] / loop_of(i));
                    check((i == 0) ? "bcd_a" : "bcd_b", (i == 0) ? bcd_a : bcd_b, e_bcd);
                    check((i == 0) ? "running_a" : "running_b", (i == 0) ? running_a : running_b,
                          16'(m_mode[i] == M_RUN));
                    check((i == 0) ? "overflow_a" : "overflow_b", (i == 0) ? overflow_a : overflow_b,
                          16'(m_mode[i] == M_OVF));
                end
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;

        rst = 1'b1;
        cyc(3);
        check("rst_bcd", bcd_a, 16'h0000);
        check("rst_running", 16'(running_a), 16'h0000);
        check("rst_overflow", 16'(overflow_b), 16'h0000);
        rst = 1'b0;
        cyc(2);

        // Start press: running appears on the 3rd edge after the sampling edge.
        start_stop = 1'b1;
        k = 0;
        do begin cyc(1); k++; end while (!running_a && k < 10);
        check("start_latency", 16'(k), 16'd4);
        start_stop = 1'b0;
        cyc(250);
        check("bcd_after_250", bcd_a, 16'h0025);
        check("running_after_250", 16'(running_a), 16'h0001);

        // Pause with prescaler at 4, hold, resume: next tick 6 cycles after re-entry.
        k = 0;
        while ((m_n[0] % LOOP_A) != 0 && k < 20) begin cyc(1); k++; end
        start_stop = 1'b1;
        k = 0;
        do begin cyc(1); k++; end while (running_a && k < 10);
        start_stop = 1'b0;
        check("pause_entered", 16'(running_a), 16'h0000);
        cyc(50);
        check("pause_hold_bcd", bcd_a, 16'h0025);
        start_stop = 1'b1;
        k = 0;
        do begin cyc(1); k++; end while (!running_a && k < 10);
        start_stop = 1'b0;
        check("resume_running", 16'(running_a), 16'h0001);
        k = 0;
        do begin cyc(1); k++; end while (bcd_a == 16'h0025 && k < 20);
        check("resume_tick_latency", 16'(k), 16'd6);
        check("resume_bcd", bcd_a, 16'h0026);

        // Start pulse landing on a tick: increment applied and PAUSE entered.
        k = 0;
        while ((m_n[0] % LOOP_A) != (LOOP_A - 4) && k < 20) begin cyc(1); k++; end
        start_stop = 1'b1;
        k = 0;
        do begin cyc(1); k++; end while (running_a && k < 10);
        start_stop = 1'b0;
        check("tick_start_bcd", bcd_a, 16'h0027);
        check("tick_start_running", 16'(running_a), 16'h0000);

        // Resume, then simultaneous start and clear: clear wins.
        start_stop = 1'b1;
        k = 0;
        do begin cyc(1); k++; end while (!running_a && k < 10);
        start_stop = 1'b0;
        cyc(5);
        start_stop = 1'b1;
        clear      = 1'b1;
        k = 0;
        do begin cyc(1); k++; end while (running_a && k < 10);
        start_stop = 1'b0;
        clear      = 1'b0;
        cyc(3);
        check("start_clear_bcd", bcd_a, 16'h0000);
        check("start_clear_running", 16'(running_a), 16'h0000);

        // Overflow path on the LOOP=2 instance.
        start_stop = 1'b1;
        k = 0;
        do begin cyc(1); k++; end while (!running_b && k < 10);
        start_stop = 1'b0;
        k = 0;
        while (bcd_b != 16'h0999 && k < 5000) begin cyc(1); k++; end
        check("reach_0999", bcd_b, 16'h0999);
        k = 0;
        do begin cyc(1); k++; end while (bcd_b == 16'h0999 && k < 5);
        check("carry_to_1000", bcd_b, 16'h1000);
        k = 0;
        while (bcd_b != 16'h9999 && k < 25000) begin cyc(1); k++; end
        check("reach_9999", bcd_b, 16'h9999);
        check("pre_ovf_flag", 16'(overflow_b), 16'h0000);
        cyc(LOOP_B);
        check("ovf_bcd", bcd_b, 16'h9999);
        check("ovf_flag", 16'(overflow_b), 16'h0001);
        check("ovf_running", 16'(running_b), 16'h0000);
        start_stop = 1'b1;
        cyc(6);
        start_stop = 1'b0;
        cyc(4);
        check("ovf_start_ignored_bcd", bcd_b, 16'h9999);
        check("ovf_start_ignored_flag", 16'(overflow_b), 16'h0001);
        clear = 1'b1;
        k = 0;
        do begin cyc(1); k++; end while (overflow_b && k < 10);
        clear = 1'b0;
        check("ovf_clear_bcd", bcd_b, 16'h0000);
        check("ovf_clear_flag", 16'(overflow_b), 16'h0000);
        cyc(5);

        // Button held through reset must not fire until released and pressed again.
        start_stop = 1'b1;
        rst        = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(10);
        check("held_through_rst", 16'(running_a), 16'h0000);
        start_stop = 1'b0;
        cyc(3);
        start_stop = 1'b1;
        k = 0;
        do begin cyc(1); k++; end while (!running_a && k < 10);
        check("rearm_latency", 16'(k), 16'd4);
        start_stop = 1'b0;

        // Reset in RUN overrides buttons.
        cyc(20);
        rst        = 1'b1;
        clear      = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        check("rst_mid_run_bcd", bcd_a, 16'h0000);
        check("rst_mid_run_running", 16'(running_a), 16'h0000);
        rst = 1'b0;
        cyc(3);
        clear      = 1'b0;
        start_stop = 1'b0;
        cyc(5);
        check("after_rst_idle", 16'(running_a), 16'h0000);

        // Random button activity with occasional reset.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 39) == 0)  start_stop = ~start_stop;
            if ($urandom_range(0, 149) == 0) clear      = ~clear;
        end
        rst        = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL provide parameter CLK_HZ, default 100_000_000, meaning input clock frequency in Hz.
REQ-002 The block SHALL provide parameter TICK_HZ, default 100, meaning count resolution (hundredths of a second).
REQ-003 The block SHALL derive localparam LOOP = CLK_HZ/TICK_HZ; the legal range is LOOP >= 2, and the prescaler width is the ceiling log2 of LOOP.
REQ-004 clk100MHz  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start_stop  input  1  debounced button level, asynchronous to clk100MHz.
REQ-007 clear  input  1  debounced button level, asynchronous to clk100MHz.
REQ-008 bcd  output  16  time as {d3,d2,d1,d0} BCD digits, meaning d3d2.d1d0 seconds (00.00-99.99); registered.
REQ-009 running  output  1  high in state RUN only; registered.
REQ-010 overflow  output  1  high in state OVF only; registered.

Function
REQ-011 Each button SHALL pass through a 2-FF synchronizer plus one history register; a one-cycle pulse SHALL be generated on a 0->1 transition of the second synchronizer stage.
REQ-012 A button edge SHALL affect state and outputs at the 3rd rising clock edge after the first edge that samples the input high; pulses SHALL NOT repeat while the button is held.
REQ-013 FSM states SHALL be IDLE, RUN, PAUSE and OVF.
REQ-014 IDLE: bcd=0 and prescaler=0; a start pulse SHALL move the FSM to RUN.
REQ-015 RUN: a start pulse SHALL move the FSM to PAUSE; a clear pulse SHALL move it to IDLE; reaching the overflow condition SHALL move it to OVF.
REQ-016 PAUSE: a start pulse SHALL move the FSM to RUN; a clear pulse SHALL move it to IDLE; bcd and prescaler SHALL be held.
REQ-017 OVF: bcd SHALL be held at 16'h9999; start pulses SHALL be ignored; a clear pulse SHALL move the FSM to IDLE.
REQ-018 Entering IDLE SHALL zero bcd and the prescaler on the same edge as the state change.
REQ-019 When clear and start pulses occur in the same cycle, clear SHALL take priority.
REQ-020 The prescaler SHALL count 0..LOOP-1 only in RUN and wrap to 0; the internal tick SHALL be asserted when the prescaler equals LOOP-1 in RUN.
REQ-021 On tick, bcd SHALL increment as a 4-digit decimal counter: each digit wraps 9->0 and carries into the next digit.
REQ-022 A tick at 16'h9999 SHALL leave bcd at 16'h9999 and enter OVF; a wrap to 0000 SHALL never occur.
REQ-023 When a tick and a start pulse occur in the same RUN cycle, the increment SHALL be applied and the FSM SHALL enter PAUSE.
REQ-024 When a tick and a clear pulse occur in the same cycle, the result SHALL be IDLE with bcd=0.
REQ-025 Resuming from PAUSE SHALL continue from the held prescaler value, so partial intervals are not lost.
REQ-026 The first increment after IDLE->RUN SHALL occur exactly LOOP cycles after the transition edge.

Reset
REQ-027 On rst high at a rising edge: state=IDLE, bcd=16'h0000, running=0, overflow=0, prescaler=0.
REQ-028 On rst high at a rising edge, all synchronizer and history registers SHALL be set to 1, so a button held through reset produces no pulse until it is released and pressed again.
REQ-029 rst asserted mid-RUN or mid-OVF SHALL override all other inputs in that cycle.

Verification (CLK_HZ=1000, TICK_HZ=100, so LOOP=10)
REQ-030 Reset, press start, wait 250 cycles -> running=1, bcd=16'h0025 (+/-1 tick accounting for the 3-cycle sync latency, checked exactly against the edge per REQ-012).
REQ-031 Run to 16'h0999, one more tick -> bcd=16'h1000; run to 16'h9999, one more tick -> bcd=16'h9999, overflow=1, running=0.
REQ-032 In OVF press start -> no change; press clear -> bcd=0, state IDLE, overflow=0.
REQ-033 Pause when prescaler=4, hold 50 cycles -> bcd unchanged; resume -> next increment exactly 6 cycles after the RUN re-entry edge.
REQ-034 Assert start and clear edges simultaneously in RUN -> IDLE, bcd=0, running=0; a tick coinciding with a start pulse -> bcd incremented and state PAUSE.
REQ-035 Hold start_stop high through rst and release rst -> FSM stays in IDLE; release then press -> RUN 3 edges later.
